// File: rtl/alu_result_fifo.sv
// ALU result FIFO: buffers {carry, result} pairs from a non-stallable ALU, dropping on full with a sticky flag.
// Optional ALU_RES_STATS_EN adds saturating push/drop statistics counters.
module alu_result_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 8
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       in_valid,
    input  logic [WIDTH-1:0]           in_res,
    input  logic                       in_carry,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [WIDTH-1:0]           out_res,
    output logic                       out_carry,
    output logic [$clog2(DEPTH):0]     count,
    output logic                       full,
    output logic                       empty,
    output logic                       overflow,
    input  logic                       clr_ovf
`ifdef ALU_RES_STATS_EN
    ,
    output logic [15:0]                stat_wr_cnt,
    output logic [15:0]                stat_drop_cnt
`endif
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [WIDTH:0]  r_mem [DEPTH];
    logic [AW-1:0]   r_head;
    logic [AW-1:0]   r_tail;
    logic [CW-1:0]   r_count;
    logic            r_full;
    logic            r_empty;
    logic            r_ovf;

    logic            w_pop;
    logic            w_push;
    logic            w_drop;
    logic [CW-1:0]   w_count_nxt;
    logic [WIDTH:0]  w_head;

    // Handshake decode and next occupancy; a pop frees a slot for a push on the same edge.
    always_comb begin
        w_pop       = !r_empty && out_ready;
        w_push      = in_valid && (!r_full || w_pop);
        w_drop      = in_valid && r_full && !w_pop;
        w_count_nxt = r_count;
        case ({w_push, w_pop})
            2'b10:   w_count_nxt = r_count + CW'(1);
            2'b01:   w_count_nxt = r_count - CW'(1);
            default: w_count_nxt = r_count;
        endcase
    end

    // Pointers, occupancy and status flags.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_head  <= {AW{1'b0}};
            r_tail  <= {AW{1'b0}};
            r_count <= {CW{1'b0}};
            r_full  <= 1'b0;
            r_empty <= 1'b1;
        end else begin
            if (w_pop) begin
                r_head <= r_head + AW'(1);
            end else begin
                r_head <= r_head;
            end
            if (w_push) begin
                r_tail <= r_tail + AW'(1);
            end else begin
                r_tail <= r_tail;
            end
            r_count <= w_count_nxt;
            r_full  <= (w_count_nxt == CW'(DEPTH));
            r_empty <= (w_count_nxt == {CW{1'b0}});
        end
    end

    // Storage array, intentionally left unreset.
    always_ff @(posedge clk) begin
        if (!rst && w_push) begin
            r_mem[r_tail] <= {in_carry, in_res};
        end
    end

    // Sticky overflow: a drop on the same edge beats a clear.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_ovf <= 1'b0;
        end else if (w_drop) begin
            r_ovf <= 1'b1;
        end else if (clr_ovf) begin
            r_ovf <= 1'b0;
        end else begin
            r_ovf <= r_ovf;
        end
    end

`ifdef ALU_RES_STATS_EN
    logic [15:0] r_wr_cnt;
    logic [15:0] r_drop_cnt;

    // Saturating event counters, cleared only by reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr_cnt   <= 16'd0;
            r_drop_cnt <= 16'd0;
        end else begin
            if (w_push && (r_wr_cnt != 16'hFFFF)) begin
                r_wr_cnt <= r_wr_cnt + 16'd1;
            end else begin
                r_wr_cnt <= r_wr_cnt;
            end
            if (w_drop && (r_drop_cnt != 16'hFFFF)) begin
                r_drop_cnt <= r_drop_cnt + 16'd1;
            end else begin
                r_drop_cnt <= r_drop_cnt;
            end
        end
    end

    assign stat_wr_cnt   = r_wr_cnt;
    assign stat_drop_cnt = r_drop_cnt;
`endif

    assign w_head    = r_mem[r_head];
    assign out_valid = !r_empty;
    assign out_res   = r_empty ? {WIDTH{1'b0}} : w_head[WIDTH-1:0];
    assign out_carry = r_empty ? 1'b0 : w_head[WIDTH];
    assign count     = r_count;
    assign full      = r_full;
    assign empty     = r_empty;
    assign overflow  = r_ovf;

endmodule
